// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 core front end.
// Latency: none, declarations only.
// Backpressure: none here; each user defines its own flow control.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;   // addi x0, x0, 0

    typedef logic [XLEN-1:0] instr_t;
    typedef logic [XLEN-1:0] addr_t;

    // One buffered fetch result: address and the word fetched from it
    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; low address bits are dropped
    function automatic addr_t word_align(input addr_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic FIFO with synchronous flush and occupancy count; head is read combinationally.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: none internally; the caller must never push when full without popping.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full;
    logic             do_pop;

    assign full       = (count_q == (PW+1)'(DEPTH));
    assign do_pop     = pop_i & (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Pointer and occupancy update; flush discards everything including a same-cycle push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                count_d  = count_d + (PW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                count_d  = count_d - (PW+1)'(1);
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full && !do_pop && !flush_i));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, imem request issue, in-order response buffer toward decode.
// Latency: response in cycle N is presented to decode in N+1; request-to-decode minimum 2 cycles.
// Backpressure: requests are credit limited so outstanding + buffered never exceeds DEPTH.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic          run_q, run_d;
    addr_t         pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;      // accepted requests not yet answered (incl. to-be-dropped)
    logic [CW-1:0] drop_q, drop_d;    // oldest outstanding responses that belong to a stale stream

    logic          req_acc;
    logic          rsp_keep;
    logic          deq;
    logic [CW:0]   inflight;

    logic [CW-1:0] buf_count;
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_push;
    logic [CW-1:0] pcq_count;
    addr_t         pcq_head;

    assign deq      = instr_valid & instr_ready;
    assign req_acc  = imem_req_valid & imem_req_ready;
    // A response in a redirect cycle is stale by definition, as is anything still owed a drop
    assign rsp_keep = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;

    // Slots committed after this cycle's dequeue; a new request needs one free slot
    assign inflight       = {1'b0, out_q} + {1'b0, buf_count} - {{CW{1'b0}}, deq};
    assign imem_req_valid = run_q & ~redirect_valid & (inflight < DEPTH_C);
    assign imem_req_addr  = pc_q;

    assign buf_push    = '{pc: pcq_head, instr: imem_rsp_data};
    assign instr_valid = (buf_count != '0);
    assign instr       = instr_valid ? buf_head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? buf_head.pc    : RESET_PC;

    // Next-state for PC, outstanding and drop counters; redirect overrides the normal update
    always_comb begin
        run_d  = 1'b1;
        pc_d   = pc_q;
        out_d  = out_q;
        drop_d = drop_q;
        if (req_acc) begin
            pc_d  = pc_q + 32'd4;
            out_d = out_d + CW'(1);
        end
        if (imem_rsp_valid) begin
            out_d = out_d - CW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end
        if (redirect_valid) begin
            pc_d   = word_align(redirect_pc);
            drop_d = out_d;
        end
    end

    // Fetch state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            run_q  <= run_d;
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    // Decoded-side buffer of {pc, instr}; cleared by redirect
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_instr_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (rsp_keep),
        .push_dat_i (buf_push),
        .pop_i      (deq),
        .flush_i    (redirect_valid),
        .head_dat_o (buf_head),
        .count_o    (buf_count)
    );

    // Addresses of outstanding requests; kept across redirect so drops stay aligned
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (req_acc),
        .push_dat_i (pc_q),
        .pop_i      (imem_rsp_valid),
        .flush_i    (1'b0),
        .head_dat_o (pcq_head),
        .count_o    (pcq_count)
    );

    a_pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        pcq_count == out_q);
    a_rsp_only_when_owed: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (out_q != '0));

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        bit          rr;
        bit          ir;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_iv;
        logic [31:0] exp_ipc;
        logic [31:0] exp_instr;
    } vec_t;

    pend_t       pend[$];
    vec_t        tbl[7];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat_cur = 1;
    bit          drv_rst_n = 1'b0;
    logic [31:0] exp_req_pc;
    logic [31:0] exp_dec_pc;
    int          n_acc = 0;
    int          n_deq = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          post_redir = 1'b0;

    // Memory contents: a distinct word per address
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %08h required %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: memory model drives responses, inputs applied, outputs checked
    task automatic step(input bit rr, input bit ir, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        rst_n = drv_rst_n;
        if (!rst_n) pend.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(pend[0].addr);
            pend.delete(0);
        end
        imem_req_ready = rr;
        instr_ready    = ir;
        redirect_valid = rd;
        redirect_pc    = rpc;
        #1;
        if (rst_n) begin
            if (rd) chk("req_off_in_redirect", 32'(imem_req_valid), 32'd0);
            if (prev_wait && !rd) begin
                chk("req_valid_held", 32'(imem_req_valid), 32'd1);
                chk("req_addr_held", imem_req_addr, prev_addr);
            end
            if (post_redir) chk("flush_after_redirect", 32'(instr_valid), 32'd0);
            if (instr_valid && ir) begin
                chk("dec_pc", instr_pc, exp_dec_pc);
                chk("dec_instr", instr, memfn(exp_dec_pc));
                exp_dec_pc += 32'd4;
                n_deq++;
            end
            if (imem_req_valid && rr) begin
                chk("req_addr_seq", imem_req_addr, exp_req_pc);
                chk("outstanding_bound", 32'(pend.size() < DEPTH), 32'd1);
                pend.push_back('{imem_req_addr, cyc + lat_cur});
                exp_req_pc += 32'd4;
                n_acc++;
            end
            prev_wait  = imem_req_valid && !rr;
            prev_addr  = imem_req_addr;
            post_redir = rd;
            if (rd) begin
                exp_req_pc = {rpc[31:2], 2'b00};
                exp_dec_pc = {rpc[31:2], 2'b00};
            end
        end
        cyc++;
    endtask

    task automatic chk_reset_outputs();
        chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset_req_addr", imem_req_addr, RESET_PC);
        chk("reset_instr_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", instr, NOP);
        chk("reset_instr_pc", instr_pc, RESET_PC);
    endtask

    task automatic do_reset();
        drv_rst_n  = 1'b0;
        rst_n      = 1'b0;
        pend.delete();
        exp_req_pc = RESET_PC;
        exp_dec_pc = RESET_PC;
        prev_wait  = 1'b0;
        post_redir = 1'b0;
        n_acc      = 0;
        n_deq      = 0;
        repeat (3) step(1'b1, 1'b1, 1'b0, '0);
        chk_reset_outputs();
    endtask

    // Cycle-exact startup: row i is the i-th cycle counted from reset release
    task automatic run_table();
        drv_rst_n = 1'b1;
        lat_cur   = 1;
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rr, tbl[i].ir, 1'b0, '0);
            chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_rv));
            chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].exp_iv));
            chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].exp_ipc);
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].exp_instr);
        end
    endtask

    // Redirect from a steady stream at memory latency lat; target must appear at R+lat+2
    task automatic redir_test(input int lat, input logic [31:0] tgt);
        int r;
        int first;
        logic [31:0] tgt_al;
        tgt_al  = {tgt[31:2], 2'b00};
        lat_cur = lat;
        repeat (6) step(1'b1, 1'b1, 1'b0, '0);
        r = cyc;
        step(1'b1, 1'b1, 1'b1, tgt);
        first = -1;
        for (int k = 0; k < 12 && first < 0; k++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (k == 0) begin
                chk("redir_next_req_valid", 32'(imem_req_valid), 32'd1);
                chk("redir_next_req_addr", imem_req_addr, tgt_al);
            end
            if (instr_valid) first = cyc - 1;
        end
        chk("redir_latency", 32'(first - r), 32'(lat + 2));
        chk("redir_first_pc", instr_pc, tgt_al);
        repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0;
        bit rd;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, RESET_PC, NOP};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, RESET_PC, NOP};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, RESET_PC, NOP};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, memfn(32'h0)};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, memfn(32'h4)};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, memfn(32'h8)};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, memfn(32'hC)};

        do_reset();
        run_table();

        // Decode stalls for 10 cycles: credits fill, requests stop, nothing is lost
        a0 = n_acc;
        repeat (10) step(1'b1, 1'b0, 1'b0, '0);
        chk("stall_req_valid_low", 32'(imem_req_valid), 32'd0);
        chk("stall_instr_held", 32'(instr_valid), 32'd1);
        chk("stall_accepts_bounded", 32'(n_acc - a0 <= DEPTH), 32'd1);
        chk("stall_credits_used", 32'(n_acc - n_deq), 32'(DEPTH));
        d0 = n_deq;
        repeat (10) step(1'b1, 1'b1, 1'b0, '0);
        chk("resume_throughput", 32'(n_deq - d0), 32'd10);

        // Redirects: two in flight, coincident response, PC wrap, longer latency
        redir_test(2, 32'h0000_0103);
        redir_test(1, 32'h0000_0200);
        redir_test(1, 32'hFFFF_FFF9);
        redir_test(3, 32'h0000_1000);

        // Random handshakes, latencies and redirects
        d0 = n_deq;
        for (int i = 0; i < 800; i++) begin
            lat_cur = $urandom_range(1, 3);
            rd      = ($urandom_range(0, 39) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rd, $urandom());
        end
        chk("random_progress", 32'(n_deq - d0 > 100), 32'd1);

        // Reset asserted mid-stream, away from a clock edge
        lat_cur = 1;
        repeat (5) step(1'b1, 1'b1, 1'b0, '0);
        #1;
        drv_rst_n = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk_reset_outputs();
        do_reset();
        run_table();
        repeat (5) step(1'b1, 1'b1, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
